// File: rtl/mini_cnn_mc_unit.sv
// Multi-channel mini CNN compute unit: streams in CHANNELS pixel/kernel windows,
// then reduces them with MAC, MAC+ReLU, max-pool or sum-pool into one saturated result.
module mini_cnn_mc_unit #(
    parameter int WINDOW   = 3,
    parameter int CHANNELS = 2,
    parameter int DATA_W   = 8,
    parameter int ACC_W    = 32,
    parameter int OUT_W    = 16,
    localparam int NN      = WINDOW * WINDOW,
    localparam int TOTAL   = CHANNELS * NN,
    localparam int DEPTH   = 2 * TOTAL,
    localparam int IDX_W   = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     load_start,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in_data,
    input  logic                     start,
    input  logic [1:0]               mode,
    input  logic [4:0]               shift,
    input  logic signed [ACC_W-1:0]  bias,
    output logic signed [OUT_W-1:0]  result_out,
    output logic                     result_valid,
    output logic                     busy,
    output logic                     overflow_flag,
    output logic [IDX_W-1:0]         current_index
);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, FINISH} state_t;

    localparam logic [1:0] M_MAC  = 2'b00;
    localparam logic [1:0] M_RELU = 2'b01;
    localparam logic [1:0] M_MAX  = 2'b10;
    localparam logic [1:0] M_SUM  = 2'b11;

    localparam logic signed [ACC_W-1:0] MAX_SEED =
        {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    // Accumulator saturation: the ACC_W+1 bit sum overflowed when its top two bits differ.
    function automatic logic acc_clips(input logic signed [ACC_W:0] x);
        return x[ACC_W] != x[ACC_W-1];
    endfunction

    function automatic logic signed [ACC_W-1:0] sat_acc(input logic signed [ACC_W:0] x);
        if (!acc_clips(x))
            return x[ACC_W-1:0];
        return x[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    endfunction

    function automatic logic out_clips(input logic signed [ACC_W-1:0] x);
        return x[ACC_W-1:OUT_W-1] != {(ACC_W-OUT_W+1){x[ACC_W-1]}};
    endfunction

    function automatic logic signed [OUT_W-1:0] sat_out(input logic signed [ACC_W-1:0] x);
        if (!out_clips(x))
            return x[OUT_W-1:0];
        return x[ACC_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
    endfunction

    // Floor shift for the arithmetic modes; max-pool passes through untouched.
    function automatic logic signed [ACC_W-1:0] requant(input logic signed [ACC_W-1:0] a,
                                                        input logic [1:0] md,
                                                        input logic [4:0] sh);
        logic signed [ACC_W-1:0] s;
        s = a >>> sh;
        if (md == M_MAX)
            return a;
        if (md == M_RELU && s < 0)
            return '0;
        return s;
    endfunction

    state_t                    state;
    logic signed [DATA_W-1:0]  mem [DEPTH];
    logic [IDX_W-1:0]          idx;
    logic signed [ACC_W-1:0]   acc;
    logic [1:0]                mode_q;
    logic [4:0]                shift_q;

    logic [IDX_W-1:0]          ker_addr;
    logic signed [DATA_W-1:0]  pix_k, ker_k;
    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W:0]     term, sum_ext;
    logic signed [ACC_W-1:0]   pix_ext, fin_val;

    assign current_index = idx;
    assign ker_addr      = idx + IDX_W'(TOTAL);

    always_comb begin
        pix_k   = mem[idx];
        ker_k   = mem[ker_addr];
        prod    = pix_k * ker_k;
        pix_ext = {{(ACC_W-DATA_W){pix_k[DATA_W-1]}}, pix_k};
        if (mode_q == M_SUM)
            term = {{(ACC_W+1-DATA_W){pix_k[DATA_W-1]}}, pix_k};
        else
            term = {{(ACC_W+1-2*DATA_W){prod[2*DATA_W-1]}}, prod};
        sum_ext = {acc[ACC_W-1], acc} + term;
        fin_val = requant(acc, mode_q, shift_q);
    end

    // Window buffer holds data only, so it is written without reset.
    always_ff @(posedge clk) begin
        if (state == LOAD && in_valid && in_ready)
            mem[idx] <= in_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            idx           <= '0;
            acc           <= '0;
            mode_q        <= M_MAC;
            shift_q       <= '0;
            result_out    <= '0;
            result_valid  <= 1'b0;
            busy          <= 1'b0;
            overflow_flag <= 1'b0;
            in_ready      <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            case (state)
                IDLE: begin
                    idx <= '0;
                    if (load_start) begin
                        state    <= LOAD;
                        in_ready <= 1'b1;
                        busy     <= 1'b1;
                    end else if (start) begin
                        state         <= RUN;
                        busy          <= 1'b1;
                        mode_q        <= mode;
                        shift_q       <= shift;
                        overflow_flag <= 1'b0;
                        case (mode)
                            M_MAX:   acc <= MAX_SEED;
                            M_SUM:   acc <= '0;
                            default: acc <= bias;
                        endcase
                    end
                end
                LOAD: begin
                    if (in_valid && in_ready) begin
                        if (idx == IDX_W'(DEPTH-1)) begin
                            state    <= IDLE;
                            in_ready <= 1'b0;
                            busy     <= 1'b0;
                            idx      <= '0;
                        end else begin
                            idx <= idx + IDX_W'(1);
                        end
                    end
                end
                RUN: begin
                    if (mode_q == M_MAX) begin
                        if (pix_ext > acc)
                            acc <= pix_ext;
                    end else begin
                        acc <= sat_acc(sum_ext);
                        if (acc_clips(sum_ext))
                            overflow_flag <= 1'b1;
                    end
                    if (idx == IDX_W'(TOTAL-1)) begin
                        state <= FINISH;
                        idx   <= '0;
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                FINISH: begin
                    result_out   <= sat_out(fin_val);
                    result_valid <= 1'b1;
                    if (out_clips(fin_val))
                        overflow_flag <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mini_cnn_mc_unit.sv
// Scoreboard bench for mini_cnn_mc_unit: a 32-bit and a 16-bit accumulator build
// receive identical stimulus and are compared against a behavioural model.
module tb_mini_cnn_mc_unit;

    localparam int TOTAL = 18;
    localparam int WORDS = 36;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic load_start = 1'b0;
    logic in_valid = 1'b0;
    logic signed [7:0] in_data = '0;
    logic start = 1'b0;
    logic [1:0] mode = '0;
    logic [4:0] shift = '0;
    logic signed [31:0] bias = '0;
    logic signed [15:0] bias_s;

    logic in_ready, result_valid, busy, overflow_flag;
    logic signed [15:0] result_out;
    logic [5:0] current_index;
    logic in_ready_s, result_valid_s, busy_s, overflow_flag_s;
    logic signed [15:0] result_out_s;
    logic [5:0] current_index_s;

    assign bias_s = bias[15:0];

    always #5 clk = ~clk;

    mini_cnn_mc_unit dut (
        .clk(clk), .reset(reset), .load_start(load_start), .in_valid(in_valid),
        .in_ready(in_ready), .in_data(in_data), .start(start), .mode(mode),
        .shift(shift), .bias(bias), .result_out(result_out),
        .result_valid(result_valid), .busy(busy), .overflow_flag(overflow_flag),
        .current_index(current_index)
    );

    mini_cnn_mc_unit #(.ACC_W(16), .OUT_W(16)) dut_s (
        .clk(clk), .reset(reset), .load_start(load_start), .in_valid(in_valid),
        .in_ready(in_ready_s), .in_data(in_data), .start(start), .mode(mode),
        .shift(shift), .bias(bias_s), .result_out(result_out_s),
        .result_valid(result_valid_s), .busy(busy_s), .overflow_flag(overflow_flag_s),
        .current_index(current_index_s)
    );

    int n_checks = 0;
    int n_pass = 0;
    int pix [TOTAL];
    int ker [TOTAL];
    longint q_res_m [$];
    longint q_ov_m  [$];
    longint q_res_s [$];
    longint q_ov_s  [$];

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got == exp)
            n_pass++;
        else
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    function automatic void model(input int md, input int sh, input longint bs,
                                  input int accw, input int outw,
                                  output longint res, output longint ov);
        longint amax, amin, omax, omin, acc, v;
        amax = (longint'(1) <<< (accw - 1)) - 1;
        amin = -amax - 1;
        omax = (longint'(1) <<< (outw - 1)) - 1;
        omin = -omax - 1;
        ov = 0;
        case (md)
            2: acc = -128;
            3: acc = 0;
            default: acc = bs;
        endcase
        for (int k = 0; k < TOTAL; k++) begin
            if (md == 2) begin
                if (pix[k] > acc) acc = pix[k];
            end else begin
                acc += (md == 3) ? longint'(pix[k]) : longint'(pix[k] * ker[k]);
                if (acc > amax) begin acc = amax; ov = 1; end
                if (acc < amin) begin acc = amin; ov = 1; end
            end
        end
        v = (md == 2) ? acc : (acc >>> sh);
        if (md == 1 && v < 0) v = 0;
        if (v > omax) begin v = omax; ov = 1; end
        if (v < omin) begin v = omin; ov = 1; end
        res = v;
    endfunction

    always @(negedge clk) begin
        if (result_valid) begin
            if (q_res_m.size() == 0)
                check("spurious_valid_m", 1, 0);
            else begin
                check("result_m", result_out, q_res_m.pop_front());
                check("ovf_m", overflow_flag, q_ov_m.pop_front());
            end
        end
        if (result_valid_s) begin
            if (q_res_s.size() == 0)
                check("spurious_valid_s", 1, 0);
            else begin
                check("result_s", result_out_s, q_res_s.pop_front());
                check("ovf_s", overflow_flag_s, q_ov_s.pop_front());
            end
        end
    end

    task automatic fill(input int pv, input int kv);
        for (int k = 0; k < TOTAL; k++) begin
            pix[k] = pv;
            ker[k] = kv;
        end
    endtask

    task automatic do_load(input bit toggle, input bit with_start);
        int n, g;
        bit drv;
        @(negedge clk);
        load_start = 1'b1;
        start = with_start;
        @(negedge clk);
        load_start = 1'b0;
        start = 1'b0;
        if (with_start) begin
            check("both_in_ready", in_ready, 1);
            check("both_busy", busy, 1);
        end
        n = 0;
        g = 0;
        while (n < WORDS && g < 400) begin
            start = toggle && (g == 7);
            if (in_ready) begin
                drv = !toggle || (g % 2 == 0);
                if (toggle) check("load_index", current_index, n);
                in_valid = drv;
                in_data = (n < TOTAL) ? 8'(pix[n]) : 8'(ker[n - TOTAL]);
                if (drv) n++;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            g++;
        end
        in_valid = 1'b0;
        start = 1'b0;
        check("load_words", n, WORDS);
        check("ready_drop", in_ready, 0);
        check("ready_drop_s", in_ready_s, 0);
        check("busy_after_load", busy, 0);
    endtask

    task automatic run_op(input int md, input int sh, input longint bs,
                          input bit fixed, input longint want, input longint want_ov);
        longint r, o;
        int lat;
        model(md, sh, bs, 32, 16, r, o);
        if (fixed) begin
            r = want;
            o = want_ov;
        end
        q_res_m.push_back(r);
        q_ov_m.push_back(o);
        model(md, sh, longint'(bs[15:0] ^ 16'h8000) - 32768, 16, 16, r, o);
        q_res_s.push_back(r);
        q_ov_s.push_back(o);
        @(negedge clk);
        mode = 2'(md);
        shift = 5'(sh);
        bias = 32'(bs);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        mode = ~mode;
        shift = 5'd0;
        bias = 32'sd12345;
        lat = 0;
        while (!result_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check("latency", lat, 19);
        @(negedge clk);
        check("valid_pulse", result_valid, 0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_result", result_out, 0);
        check("rst_valid", result_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_ovf", overflow_flag, 0);
        check("rst_index", current_index, 0);
        check("rst_ready", in_ready, 0);
        check("rst_index_s", current_index_s, 0);
        reset = 1'b0;

        fill(2, 3);
        do_load(0, 0);
        run_op(0, 0, 0, 1, 108, 0);

        fill(2, -3);
        do_load(0, 0);
        run_op(0, 0, 0, 1, -108, 0);
        run_op(1, 0, 0, 1, 0, 0);
        run_op(1, 0, 200, 1, 92, 0);
        fill(2, 3);
        do_load(0, 0);
        run_op(0, 2, 0, 1, 27, 0);

        for (int k = 0; k < TOTAL; k++) begin
            pix[k] = k - 9;
            ker[k] = int'($urandom_range(255)) - 128;
        end
        do_load(1, 0);
        run_op(2, 0, 0, 1, 8, 0);

        fill(4, 1);
        do_load(0, 0);
        run_op(3, 3, 0, 1, 9, 0);

        fill(-128, -128);
        do_load(0, 0);
        run_op(0, 0, 0, 1, 32767, 1);
        run_op(0, 4, 0, 1, 18432, 0);

        fill(127, 127);
        do_load(0, 0);
        run_op(0, 0, 0, 0, 0, 0);

        for (int t = 0; t < 3; t++) begin
            for (int k = 0; k < TOTAL; k++) begin
                pix[k] = int'($urandom_range(255)) - 128;
                ker[k] = int'($urandom_range(255)) - 128;
            end
            do_load(0, t == 0);
            for (int m = 0; m < 4; m++)
                run_op(m, int'($urandom_range(6)), longint'($urandom_range(4000)) - 2000, 0, 0, 0);
        end

        @(negedge clk);
        mode = 2'b00;
        shift = 5'd0;
        bias = 32'sd0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        #1;
        check("midrun_busy", busy, 0);
        check("midrun_result", result_out, 0);
        check("midrun_valid", result_valid, 0);
        check("midrun_ovf", overflow_flag, 0);
        check("midrun_index", current_index, 0);
        check("midrun_busy_s", busy_s, 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (30) @(negedge clk);
        check("no_result_after_abort", result_out, 0);
        check("queue_m_empty", q_res_m.size(), 0);
        check("queue_s_empty", q_res_s.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
